// File: rtl/prog_counter_pkg.sv
// Shared types for the programmable counter: end-of-count mode and count direction.
package prog_counter_pkg;

  typedef enum logic [1:0] {
    ModeWrap     = 2'd0,
    ModeOneShot  = 2'd1,
    ModeSaturate = 2'd2,
    ModeRsvd     = 2'd3
  } mode_e;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

endpackage

// File: rtl/prog_counter_if.sv
// Control/status bundle of prog_counter; clk and a_rst stay as plain ports.
interface prog_counter_if
  import prog_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 4
);

  logic             reset;
  logic             en;
  mode_e            mode;
  dir_e             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic [DIV_W-1:0] div;
  logic [WIDTH-1:0] count;
  logic             done;
  logic             wrap;

  modport master (
    output reset, en, mode, dir, load, load_val, limit, div,
    input  count, done, wrap
  );

  modport slave (
    input  reset, en, mode, dir, load, load_val, limit, div,
    output count, done, wrap
  );

endinterface

// File: rtl/prog_counter_tick_divider.sv
// Prescaler: emits one tick every div+1 enabled cycles; clear discards any partial count.
module tick_divider #(
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             clear,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] pcnt_q, pcnt_d;

  // Tick on reaching div, or on all-ones if div was lowered below the running count.
  always_comb begin
    tick   = en & ~clear & ((pcnt_q == div) | (pcnt_q == {DIV_W{1'b1}}));
    pcnt_d = pcnt_q;
    if (clear || tick) begin
      pcnt_d = '0;
    end else if (en) begin
      pcnt_d = pcnt_q + DIV_W'(1);
    end
  end

  // Prescaler state.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with prescaler and wrap / one-shot / saturate end-of-count.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 4
) (
  input logic          clk,
  input logic          a_rst,
  prog_counter_if.slave bus
);

  logic             tick;
  logic             terminal;
  logic [WIDTH-1:0] count_q;
  logic             done_q;
  logic             wrap_q;
  logic             frozen_q;

  tick_divider #(
    .DIV_W (DIV_W)
  ) u_tick_divider (
    .clk   (clk),
    .a_rst (a_rst),
    .clear (bus.reset | bus.load),
    .en    (bus.en),
    .div   (bus.div),
    .tick  (tick)
  );

  // Terminal depends on the direction sampled at this tick.
  always_comb begin
    terminal = 1'b0;
    if (bus.dir == DirDown) begin
      terminal = (count_q == '0);
    end else begin
      terminal = (count_q >= bus.limit);
    end
  end

  // Count, flags and one-shot freeze; wrap defaults low so it only pulses.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      count_q  <= '0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
      frozen_q <= 1'b0;
    end else if (bus.reset) begin
      count_q  <= '0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
      frozen_q <= 1'b0;
    end else if (bus.load) begin
      count_q  <= bus.load_val;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
      frozen_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (tick && !frozen_q) begin
        if (!terminal) begin
          // Moving off terminal (saturate after a direction flip) drops done.
          done_q <= 1'b0;
          if (bus.dir == DirDown) begin
            count_q <= count_q - WIDTH'(1);
          end else begin
            count_q <= count_q + WIDTH'(1);
          end
        end else begin
          case (bus.mode)
            ModeOneShot: begin
              done_q   <= 1'b1;
              frozen_q <= 1'b1;
            end
            ModeSaturate: begin
              done_q <= 1'b1;
            end
            default: begin
              wrap_q  <= 1'b1;
              count_q <= (bus.dir == DirDown) ? bus.limit : '0;
            end
          endcase
        end
      end
    end
  end

  assign bus.count = count_q;
  assign bus.done  = done_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: doc/prog_counter.md
# prog_counter

Parametrised successor to the basic `counter`, with programmable direction, terminal value, prescaler and end-of-count mode (wrap, one-shot, saturate). It keeps the existing port style: a free-running `clk`, an asynchronous `a_rst`, a synchronous `reset`, and `count`/`done` outputs. It sits in the simulation example designs as the DUT driven by the file-based stimulus drivers. All inputs are synchronous to `clk` except `a_rst`.

## Interface
- `WIDTH`, 8, count width in bits (≥2).
- `DIV_W`, 4, prescaler divide-value width (≥1).

- `clk`  in  1  single clock; all state updates on rising edge.
- `a_rst`  in  1  reset, asynchronous, active-high; clears all state immediately.
- `reset`  in  1  synchronous clear, active-high.
- `en`  in  1  count enable; gates the prescaler.
- `mode`  in  2  0=WRAP, 1=ONE_SHOT, 2=SATURATE, 3=reserved (behaves as WRAP).
- `dir`  in  1  0=up, 1=down.
- `load`  in  1  synchronous load of `load_val`.
- `load_val`  in  WIDTH  value loaded into `count`.
- `limit`  in  WIDTH  terminal value for up counting; reload value for down-wrap.
- `div`  in  DIV_W  prescale: one tick every `div`+1 enabled cycles.
- `count`  out  WIDTH  current count.
- `done`  out  1  end-of-count flag (ONE_SHOT/SATURATE).
- `wrap`  out  1  one-cycle pulse on wrap (WRAP mode).

## Operation
- Priority per edge: `a_rst` > `reset` > `load` > tick.
- Reset values (`a_rst` or `reset`):
  - `count`=0, `done`=0, `wrap`=0.
  - Prescaler=0; ONE_SHOT frozen flag cleared.
- Prescaler `pcnt` (DIV_W bits):
  - While `en`=1: increments each cycle; on reaching `div` it asserts tick and returns to 0.
  - While `en`=0: holds, no tick.
  - `div`=0: tick on every enabled cycle.
  - `div` lowered below `pcnt`: tick when `pcnt` reaches all-ones, then restart from 0.
- `load`:
  - `count`←`load_val`, `pcnt`←0, `done`←0, `wrap`←0; clears ONE_SHOT freeze.
  - No tick is taken that cycle.
- Terminal condition:
  - up: `count` ≥ `limit` (unsigned).
  - down: `count` == 0.
- On tick, not terminal: `count` ± 1 modulo 2^WIDTH.
- On tick, terminal:
  - WRAP up: `count`←0, `wrap`=1.
  - WRAP down: `count`←`limit`, `wrap`=1.
  - ONE_SHOT: `count` holds, `done`←1, counter frozen. Further ticks are ignored until `load`/`reset`/`a_rst`, even if `dir`/`mode` change.
  - SATURATE: `count` holds, `done`←1. A later tick with the opposite direction moves `count` off terminal and clears `done` on that same edge.
- `wrap` is 0 on every edge where it is not set as above.
- `mode`, `dir` and `limit` are sampled at each tick; changes take effect on the next tick and never corrupt `count`.
- `limit`=0 up:
  - WRAP: every tick pulses `wrap`, and `count` stays 0.
  - ONE_SHOT/SATURATE: the first tick sets `done`.

## Timing
- All outputs are registered; no combinational input→output paths.
- `load` → `count` = `load_val` after 1 edge.
- Tick → new `count` on the same edge the prescaler wraps.
  - `div`=N: first change N+1 enabled cycles after `load`/reset release.
- `wrap` is high for exactly one `clk` cycle per wrap event, and only with the `count` update it accompanies.
- `done` rises on the edge where terminal is detected with a tick, one tick after `count` first equals terminal.
- `a_rst`:
  - Assertion: outputs go to reset values without waiting for `clk`.
  - Deassertion: first tick after `div`+1 enabled cycles.
- `reset`/`load` mid-prescale discard the partial prescale count.

## Structure
- Package `prog_counter_pkg`:
  - `mode_e` enum (WRAP, ONE_SHOT, SATURATE, RSVD).
  - `dir_e` enum (UP, DOWN).
- Sub-module `tick_divider`:
  - Contains the prescaler: `clk`, `a_rst`, `clear` (= `reset`|`load`), `en`, `div` → `tick`.
  - Instanced once.
- Top contains the count/terminal/flag logic only.

## Test plan
- WRAP up, `limit`=5, `div`=0, `en`=1 from reset: `count` 0,1,2,3,4,5,0.
  - `wrap`=1 only on the cycle `count` returns to 0; `done` stays 0.
- WRAP down, `load_val`=2, `limit`=9, `div`=0: `count` 2,1,0,9,8.
  - `wrap` pulses on the 0→9 step.
- ONE_SHOT up, `limit`=3, `div`=2: `count` increments every 3rd enabled cycle to 3.
  - `done`=1 on the next tick; further ticks and a `dir` flip leave `count`=3.
  - `load` `load_val`=1 clears `done` and restarts counting.
- SATURATE up, `limit`=4: reaches 4, `done`=1 and holds.
  - Set `dir`=1: next tick `count`=3, `done`=0.
  - `load_val`=200 with `limit`=4 up: first tick holds at 200, `done`=1.
- `a_rst` asserted mid-count between clock edges (e.g. `count`=7, `pcnt`=1): `count`, `done`, `wrap` go to 0 immediately.
  - After release with `div`=1, first increment occurs 2 enabled cycles later.
- `en` toggled 0 for 5 cycles mid-prescale with `div`=3: `count` and `pcnt` hold; counting resumes exactly where it stopped.
  - `reset` and `load` asserted together: `count`=0 (`reset` wins).
